// File: rtl/ysyx_lsu_port_pkg.sv
// Shared definitions for the LSU request port: FSM states, funct3 codes,
// access strobes and small decode helpers used by the port and its extractor.
package ysyx_lsu_port_pkg;

    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned STRB_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RSP  = 2'd3
    } lsu_state_e;

    localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
    localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
    localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
    localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
    localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

    localparam logic [STRB_W-1:0] STRB_B = 8'h01;
    localparam logic [STRB_W-1:0] STRB_H = 8'h03;
    localparam logic [STRB_W-1:0] STRB_W4 = 8'h0f;

    // Latched context needed to post-process load data.
    typedef struct packed {
        logic [1:0]          off;
        logic [FUNCT3_W-1:0] funct3;
    } ld_ctx_t;

    // Stores only accept b/h/w; loads additionally accept bu/hu.
    function automatic logic op_legal(input logic we, input logic [FUNCT3_W-1:0] f3);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Size is encoded in funct3[1:0]; halfwords need even, words need 4-byte alignment.
    function automatic logic op_aligned(input logic [1:0] sz, input logic [1:0] off);
        logic ok;
        ok = 1'b1;
        case (sz)
            2'b01:   ok = !off[0];
            2'b10:   ok = (off == 2'b00);
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Base (unshifted) strobe for an access size.
    function automatic logic [STRB_W-1:0] op_strb(input logic [1:0] sz);
        logic [STRB_W-1:0] s;
        s = STRB_W4;
        case (sz)
            2'b00:   s = STRB_B;
            2'b01:   s = STRB_H;
            default: s = STRB_W4;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ysyx_lsu_port_ldext.sv
// Load data extractor: lane-aligns the returned word by the byte offset and
// sign/zero-extends according to funct3. Purely combinational.
module ysyx_lsu_ldext
    import ysyx_lsu_port_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          off,
    input  logic [FUNCT3_W-1:0] funct3,
    output logic [DATA_W-1:0]   data_c
);

    logic [DATA_W-1:0] shifted;

    // Shift selected byte lane down to bit 0, then extend by access type.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data_c  = shifted;
        case (funct3)
            F3_B:    data_c = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   data_c = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_H:    data_c = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   data_c = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: data_c = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu_port.sv
// LSU request port: accepts one load/store from execute, drives the arbiter's
// lsu_* handshakes until completion and returns a one-cycle response.
// Optional watchdog on bus waits: define YSYX_LSU_TIMEOUT_EN.
module ysyx_lsu_port
    import ysyx_lsu_port_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                rst,
    // execute-side request
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [FUNCT3_W-1:0] req_funct3,
    // execute-side response
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    // arbiter load port
    output logic [DATA_W-1:0]   lsu_araddr,
    output logic                lsu_arvalid,
    output logic [STRB_W-1:0]   lsu_rstrb,
    input  logic [DATA_W-1:0]   lsu_rdata,
    input  logic                lsu_rvalid,
    // arbiter store port
    output logic [DATA_W-1:0]   lsu_awaddr,
    output logic                lsu_awvalid,
    output logic [DATA_W-1:0]   lsu_wdata,
    output logic [STRB_W-1:0]   lsu_wstrb,
    output logic                lsu_wvalid,
    input  logic                lsu_wready
);

    lsu_state_e        state;
    ld_ctx_t           ctx;
    logic [DATA_W-1:0] ext_data;
    logic              bad_op;

    ysyx_lsu_ldext #(
        .DATA_W (DATA_W)
    ) u_ldext (
        .rdata  (lsu_rdata),
        .off    (ctx.off),
        .funct3 (ctx.funct3),
        .data_c (ext_data)
    );

    // Decode the incoming op: illegal encodings and misalignment fail without bus traffic.
    always_comb begin
        bad_op = !op_legal(req_we, req_funct3) || !op_aligned(req_funct3[1:0], req_addr[1:0]);
    end

`ifdef YSYX_LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Watchdog limit reached in the current bus-wait cycle.
    always_comb begin
        timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
`else
    // Without the watchdog the limit has no effect; bus waits are unbounded.
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ctx         <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            lsu_araddr  <= '0;
            lsu_arvalid <= 1'b0;
            lsu_rstrb   <= '0;
            lsu_awaddr  <= '0;
            lsu_awvalid <= 1'b0;
            lsu_wdata   <= '0;
            lsu_wstrb   <= '0;
            lsu_wvalid  <= 1'b0;
`ifdef YSYX_LSU_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
`ifdef YSYX_LSU_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        ctx.off    <= req_addr[1:0];
                        ctx.funct3 <= req_funct3;
                        if (bad_op) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (req_we) begin
                            state       <= ST_WR;
                            lsu_awaddr  <= DATA_W'(req_addr);
                            lsu_wdata   <= req_wdata;
                            lsu_wstrb   <= op_strb(req_funct3[1:0]);
                            lsu_awvalid <= 1'b1;
                            lsu_wvalid  <= 1'b1;
                        end else begin
                            state       <= ST_RD;
                            lsu_araddr  <= DATA_W'(req_addr);
                            lsu_rstrb   <= op_strb(req_funct3[1:0]);
                            lsu_arvalid <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (lsu_rvalid) begin
                        state       <= ST_RSP;
                        lsu_arvalid <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= ext_data;
                    end
`ifdef YSYX_LSU_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= ST_RSP;
                        lsu_arvalid <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_WR: begin
                    if (lsu_wready) begin
                        state       <= ST_RSP;
                        lsu_awvalid <= 1'b0;
                        lsu_wvalid  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b0;
                        rsp_rdata   <= '0;
                    end
`ifdef YSYX_LSU_TIMEOUT_EN
                    else if (timeout_hit) begin
                        state       <= ST_RSP;
                        lsu_awvalid <= 1'b0;
                        lsu_wvalid  <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_RSP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_lsu_port.sv
// Scoreboard bench for ysyx_lsu_port: directed cases then randomized ops,
// with responses checked by an independent monitor.
module tb_ysyx_lsu_port;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk, rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [2:0]    req_funct3;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [DW-1:0] lsu_araddr, lsu_rdata, lsu_awaddr, lsu_wdata;
    logic          lsu_arvalid, lsu_rvalid, lsu_awvalid, lsu_wvalid, lsu_wready;
    logic [7:0]    lsu_rstrb, lsu_wstrb;

    ysyx_lsu_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: size from funct3, legality, alignment, strobe, extension.
    function automatic int unsigned ref_size(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit ref_ok(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        return legal && ((addr % ref_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] f3);
        longint v;
        v = longint'(word >> (8 * off));
        case (f3)
            3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'd4: v = v % 256;
            3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'd5: v = v % 65536;
            default: ;
        endcase
        return 32'(v);
    endfunction

    // Present an op and hold req_valid until the DUT takes it.
    task automatic accept(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wdata);
        bit ok;
        @(posedge clk); #1;
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
    endtask

    // Full op: scoreboard push, bus-side checks and completion handshake.
    task automatic do_op(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        bit          ok;
        logic [31:0] strb;
        exp_t        e;
        ok   = ref_ok(we, f3, addr);
        strb = (32'd1 << ref_size(f3)) - 32'd1;
        e.err   = !ok;
        e.rdata = (ok && !we) ? ref_load(rdata, addr[1:0], f3) : 32'd0;
        sb.push_back(e);
        accept(we, addr, f3, wdata);
        if (!ok) begin
            repeat (2) begin
                @(negedge clk);
                check("err_no_ar", 32'(lsu_arvalid), 32'd0);
                check("err_no_aw", 32'(lsu_awvalid), 32'd0);
            end
            return;
        end
        for (int c = 0; c <= waits; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                // busy-time requests must be ignored; none may be pending at completion
                req_valid = (c < waits) ? 1'($urandom % 2) : 1'b0;
                req_we = 1'($urandom); req_funct3 = 3'($urandom); req_wdata = $urandom;
            end
            if (c == waits) begin
                if (we) lsu_wready = 1'b1;
                else begin lsu_rvalid = 1'b1; lsu_rdata = rdata; end
            end
            @(negedge clk);
            if (we) begin
                check("aw_valid", 32'(lsu_awvalid), 32'd1);
                check("w_valid",  32'(lsu_wvalid),  32'd1);
                check("aw_addr",  lsu_awaddr, addr);
                check("w_data",   lsu_wdata,  wdata);
                check("w_strb",   32'(lsu_wstrb), strb);
                check("st_no_ar", 32'(lsu_arvalid), 32'd0);
            end else begin
                check("ar_valid", 32'(lsu_arvalid), 32'd1);
                check("ar_addr",  lsu_araddr, addr);
                check("r_strb",   32'(lsu_rstrb), strb);
                check("ld_no_aw", 32'(lsu_awvalid), 32'd0);
            end
        end
        @(posedge clk); #1;
        lsu_rvalid = 1'b0; lsu_wready = 1'b0; lsu_rdata = $urandom;
        @(negedge clk);
        check("bus_drop", 32'(lsu_arvalid | lsu_awvalid | lsu_wvalid), 32'd0);
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err",   32'(rsp_err), 32'(e.err));
                check("rsp_rdata", rsp_rdata, e.rdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation stuck, got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit we;
        logic [2:0] f3;
        logic [31:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        req_funct3 = '0; lsu_rdata = '0; lsu_rvalid = 1'b0; lsu_wready = 1'b0;
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_outs", 32'(rsp_valid | rsp_err | lsu_arvalid | lsu_awvalid | lsu_wvalid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_strb", 32'({lsu_rstrb, lsu_wstrb}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed cases from the plan
        do_op(1'b0, 32'h8000_0004, 3'b010, 32'd0, 32'hDEAD_BEEF, 3);
        do_op(1'b0, 32'h8000_0003, 3'b000, 32'd0, 32'h80FF_FFFF, 1);
        do_op(1'b0, 32'h8000_0003, 3'b100, 32'd0, 32'h80FF_FFFF, 0);
        do_op(1'b1, 32'h1000_0002, 3'b001, 32'h1234_ABCD, 32'd0, 2);
        do_op(1'b0, 32'h8000_0002, 3'b010, 32'd0, 32'd0, 0);
        do_op(1'b0, 32'h8000_0000, 3'b011, 32'd0, 32'd0, 0);
        do_op(1'b1, 32'h8000_0000, 3'b100, 32'd0, 32'd0, 0);
        do_op(1'b0, 32'h8000_0002, 3'b101, 32'd0, 32'h8001_7F00, 0);

        // reset while a load is outstanding
        accept(1'b0, 32'h8000_0010, 3'b010, 32'd0);
        @(negedge clk);
        check("mid_rd_ar", 32'(lsu_arvalid), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_ar", 32'(lsu_arvalid), 32'd0);
        check("async_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        lsu_rvalid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("stray_rvalid_rsp", 32'(rsp_valid), 32'd0);
        end

        // unanswered load: watchdog or indefinite wait
`ifdef YSYX_LSU_TIMEOUT_EN
        sb.push_back('{err: 1'b1, rdata: 32'd0});
`endif
        accept(1'b0, 32'h8000_0020, 3'b010, 32'd0);
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (lsu_arvalid) cnt++;
            else break;
        end
`ifdef YSYX_LSU_TIMEOUT_EN
        check("timeout_ar_cycles", 32'(cnt), 32'(TO));
`else
        check("no_timeout_ar_held", 32'(cnt), 32'd150);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // randomized ops
        for (int n = 0; n < 150; n++) begin
            we = ($urandom % 3) == 0;
            if ($urandom % 6 == 0) f3 = 3'($urandom);
            else if (we) f3 = 3'($urandom % 3);
            else begin
                case ($urandom % 5)
                    0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
                    default: f3 = 3'd5;
                endcase
            end
            addr = $urandom;
            if ($urandom % 4 != 0) addr = addr & ~(32'(ref_size(f3)) - 32'd1);
            do_op(we, addr, f3, $urandom, $urandom, int'($urandom % 5));
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
